// File: rtl/fpu_issue_queue_if.sv
// Request, FPU-side and response signals of the FP16 FPU issue queue.
// slave: the issue queue itself. master: the request source, FPU and response sink.
interface fpu_issue_queue_if #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned NUM_OPERANDS    = 2,
    parameter int unsigned TAG_W           = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned OC_W            = $clog2(MAX_OUTSTANDING + 1)
);
    // request side
    logic                          req_valid_i;
    logic                          req_ready_o;
    logic [NUM_OPERANDS*WIDTH-1:0] req_operands_i;
    logic [3:0]                    req_op_i;
    logic [2:0]                    req_rnd_mode_i;
    logic                          flush_i;
    // issue to FPU
    logic                          fpu_valid_o;
    logic                          fpu_ready_i;
    logic [NUM_OPERANDS*WIDTH-1:0] fpu_operands_o;
    logic [3:0]                    fpu_op_o;
    logic [2:0]                    fpu_rnd_mode_o;
    logic [TAG_W-1:0]              fpu_tag_o;
    // result from FPU
    logic                          fpu_out_valid_i;
    logic                          fpu_out_ready_o;
    logic [WIDTH-1:0]              fpu_result_i;
    logic [4:0]                    fpu_status_i;
    logic [TAG_W-1:0]              fpu_tag_i;
    // response
    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic [WIDTH-1:0]              rsp_result_o;
    logic [4:0]                    rsp_status_o;
    logic [TAG_W-1:0]              rsp_tag_o;
    // status
    logic [OC_W-1:0]               outstanding_o;
    logic                          busy_o;
    logic                          tag_err_o;

    modport slave (
        input  req_valid_i, req_operands_i, req_op_i, req_rnd_mode_i, flush_i,
        input  fpu_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
        input  rsp_ready_i,
        output req_ready_o, fpu_valid_o, fpu_operands_o, fpu_op_o, fpu_rnd_mode_o,
        output fpu_tag_o, fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
        output rsp_tag_o, outstanding_o, busy_o, tag_err_o
    );

    modport master (
        output req_valid_i, req_operands_i, req_op_i, req_rnd_mode_i, flush_i,
        output fpu_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
        output rsp_ready_i,
        input  req_ready_o, fpu_valid_o, fpu_operands_o, fpu_op_o, fpu_rnd_mode_o,
        input  fpu_tag_o, fpu_out_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
        input  rsp_tag_o, outstanding_o, busy_o, tag_err_o
    );
endinterface

// File: rtl/fpu_issue_queue.sv
// FP16 FPU issue queue: DEPTH-entry request FIFO, tagged issue with an
// outstanding-op cap, registered response stage with in-order tag checking.
module fpu_issue_queue #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned NUM_OPERANDS    = 2,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned TAG_W           = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned OC_W            = $clog2(MAX_OUTSTANDING + 1)
) (
    input logic              clk_i,
    input logic              rst_i,
    fpu_issue_queue_if.slave bus
);
    localparam int unsigned     PTR_W  = $clog2(DEPTH);
    localparam int unsigned     OPW    = NUM_OPERANDS * WIDTH;
    localparam logic [OC_W-1:0] MAX_OC = OC_W'(MAX_OUTSTANDING);
    localparam logic [OC_W-1:0] OC_ONE = OC_W'(1);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [PTR_W:0]  PTR_ONE = (PTR_W + 1)'(1);

    logic [OPW-1:0]   opnd_mem [DEPTH];
    logic [3:0]       op_mem   [DEPTH];
    logic [2:0]       rnd_mem  [DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [TAG_W-1:0] issue_tag, expect_tag;
    logic [OC_W-1:0]  outstanding;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_result;
    logic [4:0]       rsp_status;
    logic [TAG_W-1:0] rsp_tag;
    logic             tag_err;

    logic empty, full, req_ready, fpu_valid, out_ready;
    logic wr_en, issue_fire, acc_fire, retire, spurious;

    // Handshake decode from registered state and current inputs.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        req_ready  = !rst_i && !full && !bus.flush_i;
        fpu_valid  = !empty && (outstanding < MAX_OC) && !bus.flush_i;
        out_ready  = !rsp_valid || bus.rsp_ready_i;
        wr_en      = bus.req_valid_i && req_ready;
        issue_fire = fpu_valid && bus.fpu_ready_i;
        acc_fire   = bus.fpu_out_valid_i && out_ready;
        retire     = acc_fire && (outstanding != '0);
        spurious   = acc_fire && (outstanding == '0);
    end

    // Request FIFO: write on enqueue, pop on issue, flush drops every queued entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                opnd_mem[i] <= '0;
                op_mem[i]   <= '0;
                rnd_mem[i]  <= '0;
            end
        end else begin
            if (wr_en) begin
                opnd_mem[wr_ptr[PTR_W-1:0]] <= bus.req_operands_i;
                op_mem[wr_ptr[PTR_W-1:0]]   <= bus.req_op_i;
                rnd_mem[wr_ptr[PTR_W-1:0]]  <= bus.req_rnd_mode_i;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (bus.flush_i) begin
                rd_ptr <= wr_ptr;
            end else if (issue_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Tag counters, outstanding count and sticky order/spurious error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_tag   <= '0;
            expect_tag  <= '0;
            outstanding <= '0;
            tag_err     <= 1'b0;
        end else begin
            if (issue_fire) begin
                issue_tag <= issue_tag + TAG_ONE;
            end
            if (retire) begin
                expect_tag <= expect_tag + TAG_ONE;
            end
            if (issue_fire && !retire) begin
                outstanding <= outstanding + OC_ONE;
            end else if (!issue_fire && retire) begin
                outstanding <= outstanding - OC_ONE;
            end
            if (spurious || (retire && (bus.fpu_tag_i != expect_tag))) begin
                tag_err <= 1'b1;
            end
        end
    end

    // Response register: load on a normal accept, drop valid when consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_status <= '0;
            rsp_tag    <= '0;
        end else if (retire) begin
            rsp_valid  <= 1'b1;
            rsp_result <= bus.fpu_result_i;
            rsp_status <= bus.fpu_status_i;
            rsp_tag    <= bus.fpu_tag_i;
        end else if (bus.rsp_ready_i) begin
            rsp_valid  <= 1'b0;
        end
    end

    assign bus.req_ready_o     = req_ready;
    assign bus.fpu_valid_o     = fpu_valid;
    assign bus.fpu_operands_o  = opnd_mem[rd_ptr[PTR_W-1:0]];
    assign bus.fpu_op_o        = op_mem[rd_ptr[PTR_W-1:0]];
    assign bus.fpu_rnd_mode_o  = rnd_mem[rd_ptr[PTR_W-1:0]];
    assign bus.fpu_tag_o       = issue_tag;
    assign bus.fpu_out_ready_o = out_ready;
    assign bus.rsp_valid_o     = rsp_valid;
    assign bus.rsp_result_o    = rsp_result;
    assign bus.rsp_status_o    = rsp_status;
    assign bus.rsp_tag_o       = rsp_tag;
    assign bus.outstanding_o   = outstanding;
    assign bus.busy_o          = !empty || (outstanding != '0) || rsp_valid;
    assign bus.tag_err_o       = tag_err;
endmodule
